// File: rtl/ktms_cnt_rsp_pkg.sv
// Shared definitions for the continue-response dispatcher: field offsets,
// FSM state encoding and error bit indices.
package ktms_cnt_rsp_pkg;

  localparam int unsigned RC_W       = 4;
  localparam int unsigned RC_LSB     = 0;
  localparam int unsigned CTAG_LSB   = RC_LSB + RC_W;

  localparam int unsigned ERR_W      = 3;
  localparam int unsigned ERR_OVF    = 0;
  localparam int unsigned ERR_CTAG   = 1;
  localparam int unsigned ERR_DUP    = 2;

  localparam int unsigned DROP_CNT_W = 16;
  // Depth of the backlog of CHK drops deferred behind coincident overflow drops
  localparam int unsigned DROP_OWE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHK   = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  // Response layout, LSB upward: rc, ctag, ctxt, addr, mask
  function automatic int unsigned ctxt_lsb(input int unsigned ctag_w);
    return CTAG_LSB + ctag_w;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned ctag_w,
                                           input int unsigned ctxt_w);
    return CTAG_LSB + ctag_w + ctxt_w;
  endfunction

  function automatic int unsigned mask_lsb(input int unsigned ctag_w,
                                           input int unsigned ctxt_w,
                                           input int unsigned pea_w);
    return CTAG_LSB + ctag_w + ctxt_w + pea_w;
  endfunction

endpackage

// File: rtl/ktms_cnt_rsp_fifo.sv
// Power-of-two response buffer with registered storage; a push while full is
// accepted only when a pop happens in the same cycle.
module ktms_cnt_rsp_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [width-1:0] i_d,
  output logic [width-1:0] o_head_c,
  output logic             o_full_c,
  output logic             o_empty_c
);

  localparam int unsigned AW = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] r_mem [depth];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full_c  = (r_cnt == (AW+1)'(depth));
  assign o_empty_c = (r_cnt == '0);
  assign o_head_c  = r_mem[r_rd_ptr];
  assign w_pop     = i_pop & ~o_empty_c;
  assign w_push    = i_push & (~o_full_c | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ktms_cnt_rsp_dispatch.sv
// Buffers continue responses, matches them against stalled command tags and
// issues restart requests in arrival order, tracking drops and errors.
module ktms_cnt_rsp_dispatch
  import ktms_cnt_rsp_pkg::*;
#(
  parameter int unsigned ctxtid_width  = 8,
  parameter int unsigned ctag_width    = 8,
  parameter int unsigned pea_width     = 52,
  parameter int unsigned cnt_rsp_width = 2*pea_width + ctxtid_width + ctag_width + 4,
  parameter int unsigned fifo_depth    = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                i_cnt_rsp_v,
  input  logic [cnt_rsp_width-1:0]            i_cnt_rsp_d,
  input  logic                                i_stall_v,
  input  logic [ctag_width-1:0]               i_stall_ctag,
  output logic                                o_rst_v,
  input  logic                                o_rst_r,
  output logic [2*pea_width+ctag_width+3:0]   o_rst_d,
  output logic                                o_perror,
  output logic [ERR_W-1:0]                    o_err,
  output logic [DROP_CNT_W-1:0]               o_drop_cnt
);

  localparam int unsigned RST_W     = 2*pea_width + ctag_width + RC_W;
  localparam int unsigned NTAGS     = 2**ctag_width;
  localparam int unsigned CTXT_LSB  = ctxt_lsb(ctag_width);
  localparam int unsigned ADDR_LSB  = addr_lsb(ctag_width, ctxtid_width);
  localparam int unsigned MASK_LSB  = mask_lsb(ctag_width, ctxtid_width, pea_width);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [cnt_rsp_width-1:0] r_hold;
  logic [NTAGS-1:0]        r_pending;
  logic [RST_W-1:0]        r_rst_d;
  logic                    r_rst_v;
  logic                    r_perror;
  logic [ERR_W-1:0]        r_err;
  logic [DROP_CNT_W-1:0]   r_drop_cnt;
  logic [DROP_OWE_W-1:0]   r_drop_owe;

  logic [cnt_rsp_width-1:0] w_head;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_pop;
  logic                     w_clr;
  logic                     w_load_rst;
  logic                     w_perr_ev;
  logic                     w_ctag_ev;
  logic                     w_chk_drop;
  logic                     w_ovf;
  logic                     w_dup;
  logic                     w_par_ok;
  logic                     w_drop_inc;
  logic [DROP_OWE_W-1:0]    w_drop_owe_nxt;

  logic [RC_W-1:0]          w_rc;
  logic [ctag_width-1:0]    w_ctag;
  logic [ctxtid_width-1:0]  w_ctxt;
  logic [pea_width-1:0]     w_addr;
  logic [pea_width-1:0]     w_mask;

  ktms_cnt_rsp_fifo #(
    .width (cnt_rsp_width),
    .depth (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (i_cnt_rsp_v),
    .i_pop     (w_pop),
    .i_d       (i_cnt_rsp_d),
    .o_head_c  (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty)
  );

  assign w_rc   = r_hold[RC_LSB   +: RC_W];
  assign w_ctag = r_hold[CTAG_LSB +: ctag_width];
  assign w_ctxt = r_hold[CTXT_LSB +: ctxtid_width];
  assign w_addr = r_hold[ADDR_LSB +: pea_width];
  assign w_mask = r_hold[MASK_LSB +: pea_width];

  // Odd parity: data bits plus the parity bit must hold an odd number of ones
  assign w_par_ok   = ^w_ctxt;
  assign w_chk_drop = w_perr_ev | w_ctag_ev;
  assign w_ovf      = i_cnt_rsp_v & w_full & ~w_pop;
  // A stall that lands on the cycle its tag is being cleared is a fresh stall
  assign w_dup      = i_stall_v & r_pending[i_stall_ctag] &
                      ~(w_clr && (w_ctag == i_stall_ctag));

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_clr       = 1'b0;
    w_load_rst  = 1'b0;
    w_perr_ev   = 1'b0;
    w_ctag_ev   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_CHK;
        end
      end
      ST_CHK: begin
        if (!w_par_ok) begin
          w_perr_ev   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (!r_pending[w_ctag]) begin
          w_ctag_ev   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_clr       = 1'b1;
          w_load_rst  = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (o_rst_r) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Overflow drops take the counter first; a coincident CHK drop is deferred
  always_comb begin
    w_drop_inc     = 1'b0;
    w_drop_owe_nxt = r_drop_owe;
    if (w_ovf) begin
      w_drop_inc = 1'b1;
      if (w_chk_drop && (r_drop_owe != '1)) w_drop_owe_nxt = r_drop_owe + DROP_OWE_W'(1);
    end else if (w_chk_drop) begin
      w_drop_inc = 1'b1;
    end else if (r_drop_owe != '0) begin
      w_drop_inc     = 1'b1;
      w_drop_owe_nxt = r_drop_owe - DROP_OWE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_hold     <= '0;
      r_rst_v    <= 1'b0;
      r_rst_d    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rst_v    <= (w_state_nxt == ST_ISSUE);
      if (w_pop)      r_hold  <= w_head;
      if (w_load_rst) r_rst_d <= {w_mask, w_addr, w_ctag, w_rc};
    end
  end

  // Set after clear so a coincident stall on the same tag wins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      if (w_clr)     r_pending[w_ctag]       <= 1'b0;
      if (i_stall_v) r_pending[i_stall_ctag] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perror   <= 1'b0;
      r_err      <= '0;
      r_drop_cnt <= '0;
      r_drop_owe <= '0;
    end else begin
      r_drop_owe <= w_drop_owe_nxt;
      if (w_perr_ev) r_perror          <= 1'b1;
      if (w_ovf)     r_err[ERR_OVF]    <= 1'b1;
      if (w_ctag_ev) r_err[ERR_CTAG]   <= 1'b1;
      if (w_dup)     r_err[ERR_DUP]    <= 1'b1;
      if (w_drop_inc && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end
  end

  assign o_rst_v    = r_rst_v;
  assign o_rst_d    = r_rst_d;
  assign o_perror   = r_perror;
  assign o_err      = r_err;
  assign o_drop_cnt = r_drop_cnt;

endmodule
